// File: rtl/cic_decimator.sv
// cic_decimator: single-channel N-stage CIC decimator, R = 2^DECIM_LOG2.
// Pipelined integrator chain, decimation strobe, comb chain and a
// bit-trimmed output register that normalises the R^N gain to unity.
// Optional: define CIC_ROUND_EN to round half up (with positive saturation)
// before the trim instead of truncating toward minus infinity.

module cic_decimator #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned STAGES     = 3,
    parameter int unsigned DECIM_LOG2 = 12
) (
    input  logic                         clk,
    input  logic                         arst,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_valid
);

    localparam int unsigned ACC_WIDTH = DATA_WIDTH + STAGES * DECIM_LOG2;
    localparam int unsigned TRIM      = ACC_WIDTH - DATA_WIDTH;
    localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;

    logic signed [ACC_WIDTH-1:0]  integ [STAGES];
    logic signed [ACC_WIDTH-1:0]  comb  [STAGES];
    logic signed [ACC_WIDTH-1:0]  dly   [STAGES];
    logic signed [ACC_WIDTH-1:0]  comb_in;
    logic        [STAGES:0]       v;
    logic        [DECIM_LOG2-1:0] cnt;
    logic signed [ACC_WIDTH-1:0]  in_ext_c;
    logic signed [DATA_WIDTH-1:0] trimmed_c;
    logic                         strobe_c;
    logic                         unused_c;

    assign in_ext_c = {{TRIM{in_data[DATA_WIDTH-1]}}, in_data};
    assign strobe_c = in_valid && (cnt == CNT_LAST);

    // Integrator chain; each stage accumulates the registered previous stage
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                integ[k] <= '0;
            end
        end else if (in_valid) begin
            integ[0] <= integ[0] + in_ext_c;
            for (int k = 1; k < int'(STAGES); k++) begin
                integ[k] <= integ[k] + integ[k-1];
            end
        end
    end

    // Decimation counter and capture of the last integrator at the strobe
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt     <= '0;
            comb_in <= '0;
            v[0]    <= 1'b0;
        end else begin
            if (in_valid) begin
                cnt <= cnt + DECIM_LOG2'(1);
            end
            if (strobe_c) begin
                comb_in <= integ[STAGES-1];
            end
            v[0] <= strobe_c;
        end
    end

    // Comb chain; a burst already launched runs to completion independent of in_valid
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                comb[k] <= '0;
                dly[k]  <= '0;
            end
            v[STAGES:1] <= '0;
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (v[k]) begin
                    if (k == 0) begin
                        comb[k] <= comb_in - dly[k];
                        dly[k]  <= comb_in;
                    end else begin
                        comb[k] <= comb[k-1] - dly[k];
                        dly[k]  <= comb[k-1];
                    end
                end
            end
            v[STAGES:1] <= v[STAGES-1:0];
        end
    end

`ifdef CIC_ROUND_EN
    localparam logic [ACC_WIDTH:0] HALF = {{ACC_WIDTH{1'b0}}, 1'b1} << (TRIM - 1);

    logic [ACC_WIDTH:0] rsum_c;

    assign rsum_c   = {comb[STAGES-1][ACC_WIDTH-1], comb[STAGES-1]} + HALF;
    assign unused_c = ^rsum_c;

    // Round half up; a carry into the sign bit clamps to the largest positive code
    always_comb begin
        trimmed_c = rsum_c[ACC_WIDTH-1 -: DATA_WIDTH];
        if (rsum_c[ACC_WIDTH] != rsum_c[ACC_WIDTH-1]) begin
            trimmed_c = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end
`else
    // Plain truncation of the low gain bits (toward minus infinity)
    assign trimmed_c = comb[STAGES-1][ACC_WIDTH-1 -: DATA_WIDTH];
    assign unused_c  = ^comb[STAGES-1];
`endif

    // Output register: sample held between updates, one-cycle valid pulse
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (v[STAGES]) begin
                out_data <= trimmed_c;
            end
            out_valid <= v[STAGES];
        end
    end

endmodule
